// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the CORDIC arbiter.
// Optional FLUSH state is enabled by defining CORDIC_ARB_FLUSH_EN.
package cordic_arb_pkg;

    localparam int MAX_OUT_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
`ifdef CORDIC_ARB_FLUSH_EN
        ,
        ST_FLUSH = 2'd3
`endif
    } arb_state_e;

    // Width of an owner index; never less than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: one-hot winner among req, searching from last_owner+1.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int OW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] winner
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(last_owner) + i) % NUM_REQ))) begin
                    winner[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Grants one requester at a time exclusive use of a shared CORDIC core.
// Defining CORDIC_ARB_FLUSH_EN adds a 2-cycle cordic_nrst pulse between owners.
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int MAX_OUT       = MAX_OUT_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               gnt,
    input  logic [NUM_REQ-1:0]               rq_vec_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    rq_vec_xin,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    rq_vec_yin,
    input  logic [NUM_REQ-1:0]               rq_vec_angle_calc_en,
    input  logic [NUM_REQ-1:0]               rq_rot_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    rq_rot_xin,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    rq_rot_yin,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0]   rq_rot_angle_in,
    input  logic [NUM_REQ*CORDIC_STAGES-1:0] rq_rot_microRot_ext_in,
    input  logic [NUM_REQ-1:0]               rq_rot_microRot_ext_vld,
    input  logic [NUM_REQ-1:0]               rq_rot_angle_microRot_n,
    input  logic [NUM_REQ*2-1:0]             rq_rot_quad_in,
    output logic                             cordic_nrst,
    output logic                             cordic_vec_en,
    output logic [DATA_WIDTH-1:0]            cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]            cordic_vec_yin,
    output logic                             cordic_vec_angle_calc_en,
    output logic                             cordic_rot_en,
    output logic [DATA_WIDTH-1:0]            cordic_rot_xin,
    output logic [DATA_WIDTH-1:0]            cordic_rot_yin,
    output logic [ANGLE_WIDTH-1:0]           cordic_rot_angle_in,
    output logic [CORDIC_STAGES-1:0]         cordic_rot_microRot_ext_in,
    output logic                             cordic_rot_microRot_ext_vld,
    output logic                             cordic_rot_angle_microRot_n,
    output logic [1:0]                       cordic_rot_quad_in,
    input  logic                             cordic_vec_opvld,
    input  logic                             cordic_rot_opvld,
    output logic [NUM_REQ-1:0]               rq_vec_opvld,
    output logic [NUM_REQ-1:0]               rq_rot_opvld,
    output logic                             err,
    output logic [1:0]                       dbg_state,
    output logic [$clog2(MAX_OUT+1)-1:0]     dbg_vec_cnt,
    output logic [$clog2(MAX_OUT+1)-1:0]     dbg_rot_cnt
);

    localparam int OW = owner_w(NUM_REQ);
    localparam int CW = $clog2(MAX_OUT + 1);

    // Where GRANT/DRAIN go once the channel is quiet.
`ifdef CORDIC_ARB_FLUSH_EN
    localparam arb_state_e EXIT_ST = ST_FLUSH;
`else
    localparam arb_state_e EXIT_ST = ST_IDLE;
`endif

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [CW-1:0]       vec_cnt_q, vec_cnt_d, rot_cnt_q, rot_cnt_d;
    logic                err_q, err_d;
    logic                vec_err, rot_err;
    logic [NUM_REQ-1:0]  winner;
    logic                req_own;
    logic                active;
`ifdef CORDIC_ARB_FLUSH_EN
    logic                flush_cnt_q, flush_cnt_d;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ), .OW(OW)) u_rr_picker (
        .req        (req),
        .last_owner (owner_q),
        .winner     (winner)
    );

    function automatic logic [OW-1:0] enc(input logic [NUM_REQ-1:0] oh);
        logic [OW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (oh[k]) idx = OW'(k);
        end
        return idx;
    endfunction

    // Returns {error, next count}. An en+opvld pair on an empty counter
    // counts the new op and drops the stray valid.
    function automatic logic [CW:0] cnt_next(input logic [CW-1:0] c, input logic fwd,
                                             input logic vld);
        logic          e;
        logic [CW-1:0] n;
        e = 1'b0;
        n = c;
        case ({fwd, vld})
            2'b10: if (c == CW'(MAX_OUT)) e = 1'b1; else n = c + 1'b1;
            2'b01: if (c == '0) e = 1'b1; else n = c - 1'b1;
            2'b11: if (c == '0) begin e = 1'b1; n = CW'(1); end
            default: ;
        endcase
        return {e, n};
    endfunction

    // Data path: everything to the CORDIC comes from the granted slice only.
    always_comb begin
        cordic_vec_en               = 1'b0;
        cordic_vec_xin              = '0;
        cordic_vec_yin              = '0;
        cordic_vec_angle_calc_en    = 1'b0;
        cordic_rot_en               = 1'b0;
        cordic_rot_xin              = '0;
        cordic_rot_yin              = '0;
        cordic_rot_angle_in         = '0;
        cordic_rot_microRot_ext_in  = '0;
        cordic_rot_microRot_ext_vld = 1'b0;
        cordic_rot_angle_microRot_n = 1'b0;
        cordic_rot_quad_in          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) begin
                cordic_vec_en               |= rq_vec_en[k];
                cordic_vec_xin              |= rq_vec_xin[k*DATA_WIDTH +: DATA_WIDTH];
                cordic_vec_yin              |= rq_vec_yin[k*DATA_WIDTH +: DATA_WIDTH];
                cordic_vec_angle_calc_en    |= rq_vec_angle_calc_en[k];
                cordic_rot_en               |= rq_rot_en[k];
                cordic_rot_xin              |= rq_rot_xin[k*DATA_WIDTH +: DATA_WIDTH];
                cordic_rot_yin              |= rq_rot_yin[k*DATA_WIDTH +: DATA_WIDTH];
                cordic_rot_angle_in         |= rq_rot_angle_in[k*ANGLE_WIDTH +: ANGLE_WIDTH];
                cordic_rot_microRot_ext_in  |= rq_rot_microRot_ext_in[k*CORDIC_STAGES +: CORDIC_STAGES];
                cordic_rot_microRot_ext_vld |= rq_rot_microRot_ext_vld[k];
                cordic_rot_angle_microRot_n |= rq_rot_angle_microRot_n[k];
                cordic_rot_quad_in          |= rq_rot_quad_in[k*2 +: 2];
            end
        end
    end

    // Result valids: opvld is a single-cycle pulse per completed op, routed
    // to the owner only while it holds or drains the channel and has an op
    // outstanding; there is no back-pressure on either side.
    assign active = (state_q == ST_GRANT) || (state_q == ST_DRAIN);

    always_comb begin
        rq_vec_opvld = '0;
        rq_rot_opvld = '0;
        req_own      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (OW'(k) == owner_q) begin
                req_own         = req[k];
                rq_vec_opvld[k] = active && cordic_vec_opvld && (vec_cnt_q != '0);
                rq_rot_opvld[k] = active && cordic_rot_opvld && (rot_cnt_q != '0);
            end
        end
    end

    always_comb begin
        {vec_err, vec_cnt_d} = cnt_next(vec_cnt_q, cordic_vec_en, cordic_vec_opvld);
        {rot_err, rot_cnt_d} = cnt_next(rot_cnt_q, cordic_rot_en, cordic_rot_opvld);
        err_d   = err_q | vec_err | rot_err;
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
`ifdef CORDIC_ARB_FLUSH_EN
        flush_cnt_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = winner;
                    owner_d = enc(winner);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req_own) begin
                    gnt_d   = '0;
                    state_d = (vec_cnt_d == '0 && rot_cnt_d == '0) ? EXIT_ST : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vec_cnt_d == '0 && rot_cnt_d == '0) state_d = EXIT_ST;
            end
`ifdef CORDIC_ARB_FLUSH_EN
            ST_FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= OW'(NUM_REQ - 1);
            vec_cnt_q   <= '0;
            rot_cnt_q   <= '0;
            err_q       <= 1'b0;
`ifdef CORDIC_ARB_FLUSH_EN
            flush_cnt_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            vec_cnt_q   <= vec_cnt_d;
            rot_cnt_q   <= rot_cnt_d;
            err_q       <= err_d;
`ifdef CORDIC_ARB_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

`ifdef CORDIC_ARB_FLUSH_EN
    assign cordic_nrst = rstn & (state_q != ST_FLUSH);
`else
    assign cordic_nrst = rstn;
`endif

    assign gnt         = gnt_q;
    assign err         = err_q;
    assign dbg_state   = state_q;
    assign dbg_vec_cnt = vec_cnt_q;
    assign dbg_rot_cnt = rot_cnt_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: CORDIC latency stub plus an
// integer-level reference model of the grant/drain rules.
module tb_cordic_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int ST = 16;
  localparam int MO = 24;
  localparam int CW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [N-1:0] rq_vec_en = '0;
  logic [N*DW-1:0] rq_vec_xin = '0, rq_vec_yin = '0;
  logic [N-1:0] rq_vec_angle_calc_en = '0;
  logic [N-1:0] rq_rot_en = '0;
  logic [N*DW-1:0] rq_rot_xin = '0, rq_rot_yin = '0;
  logic [N*AW-1:0] rq_rot_angle_in = '0;
  logic [N*ST-1:0] rq_rot_microRot_ext_in = '0;
  logic [N-1:0] rq_rot_microRot_ext_vld = '0, rq_rot_angle_microRot_n = '0;
  logic [N*2-1:0] rq_rot_quad_in = '0;
  logic cordic_nrst, cordic_vec_en, cordic_vec_angle_calc_en, cordic_rot_en;
  logic [DW-1:0] cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin;
  logic [AW-1:0] cordic_rot_angle_in;
  logic [ST-1:0] cordic_rot_microRot_ext_in;
  logic cordic_rot_microRot_ext_vld, cordic_rot_angle_microRot_n;
  logic [1:0] cordic_rot_quad_in;
  logic cordic_vec_opvld = 1'b0, cordic_rot_opvld = 1'b0;
  logic [N-1:0] rq_vec_opvld, rq_rot_opvld;
  logic err;
  logic [1:0] dbg_state;
  logic [CW-1:0] dbg_vec_cnt, dbg_rot_cnt;

  cordic_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW),
                   .CORDIC_STAGES(ST), .MAX_OUT(MO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt),
    .rq_vec_en(rq_vec_en), .rq_vec_xin(rq_vec_xin), .rq_vec_yin(rq_vec_yin),
    .rq_vec_angle_calc_en(rq_vec_angle_calc_en),
    .rq_rot_en(rq_rot_en), .rq_rot_xin(rq_rot_xin), .rq_rot_yin(rq_rot_yin),
    .rq_rot_angle_in(rq_rot_angle_in), .rq_rot_microRot_ext_in(rq_rot_microRot_ext_in),
    .rq_rot_microRot_ext_vld(rq_rot_microRot_ext_vld),
    .rq_rot_angle_microRot_n(rq_rot_angle_microRot_n), .rq_rot_quad_in(rq_rot_quad_in),
    .cordic_nrst(cordic_nrst), .cordic_vec_en(cordic_vec_en),
    .cordic_vec_xin(cordic_vec_xin), .cordic_vec_yin(cordic_vec_yin),
    .cordic_vec_angle_calc_en(cordic_vec_angle_calc_en),
    .cordic_rot_en(cordic_rot_en), .cordic_rot_xin(cordic_rot_xin),
    .cordic_rot_yin(cordic_rot_yin), .cordic_rot_angle_in(cordic_rot_angle_in),
    .cordic_rot_microRot_ext_in(cordic_rot_microRot_ext_in),
    .cordic_rot_microRot_ext_vld(cordic_rot_microRot_ext_vld),
    .cordic_rot_angle_microRot_n(cordic_rot_angle_microRot_n),
    .cordic_rot_quad_in(cordic_rot_quad_in),
    .cordic_vec_opvld(cordic_vec_opvld), .cordic_rot_opvld(cordic_rot_opvld),
    .rq_vec_opvld(rq_vec_opvld), .rq_rot_opvld(rq_rot_opvld), .err(err),
    .dbg_state(dbg_state), .dbg_vec_cnt(dbg_vec_cnt), .dbg_rot_cnt(dbg_rot_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- CORDIC stub: fixed ST-cycle latency ----------------
  logic [ST-1:0] vp = '0, rp = '0;
  bit stub_on = 1'b1;
  bit spur_vec = 1'b0, spur_rot = 1'b0;

  task automatic upd_opvld();
    cordic_vec_opvld = (stub_on & vp[ST-1]) | spur_vec;
    cordic_rot_opvld = (stub_on & rp[ST-1]) | spur_rot;
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 owner holds channel, 2 waiting for results, 3 flushing
  int m_phase, m_own, m_last, m_vc, m_rc, m_fl;
  bit m_err;
  int pulses0 = 0;
  int nrst_low = 0;

  task automatic model_reset();
    m_phase = 0; m_last = N - 1; m_own = N - 1;
    m_vc = 0; m_rc = 0; m_fl = 0; m_err = 1'b0;
  endtask

  function automatic int count_after(input int c, input bit f, input bit v, inout bit e);
    if (f && !v) begin
      if (c == MO) e = 1'b1; else c++;
    end else if (v && !f) begin
      if (c == 0) e = 1'b1; else c--;
    end else if (f && v && c == 0) begin
      e = 1'b1; c = 1;
    end
    return c;
  endfunction

  task automatic quiet_exit();
`ifdef CORDIC_ARB_FLUSH_EN
    m_phase = 3; m_fl = 0;
`else
    m_phase = 0;
`endif
  endtask

  // One clock: check outputs at negedge against the model, advance the model,
  // then feed the stub and return at posedge+1 for the next drive.
  task automatic step();
    bit g, act, ve, re;
    logic [N-1:0] oh;
    bit found;
    int k;
    @(negedge clk);
    g   = (m_phase == 1);
    act = (m_phase == 1) || (m_phase == 2);
    oh  = '0;
    oh[m_own] = 1'b1;
    ve = g && rq_vec_en[m_own];
    re = g && rq_rot_en[m_own];
    check_eq("gnt", gnt, g ? oh : '0);
    check_eq("vec_en", cordic_vec_en, ve);
    check_eq("rot_en", cordic_rot_en, re);
    check_eq("vec_xin", cordic_vec_xin, g ? rq_vec_xin[m_own*DW +: DW] : '0);
    check_eq("vec_yin", cordic_vec_yin, g ? rq_vec_yin[m_own*DW +: DW] : '0);
    check_eq("rot_xin", cordic_rot_xin, g ? rq_rot_xin[m_own*DW +: DW] : '0);
    check_eq("rot_angle", cordic_rot_angle_in, g ? rq_rot_angle_in[m_own*AW +: AW] : '0);
    check_eq("rot_urot", cordic_rot_microRot_ext_in,
             g ? rq_rot_microRot_ext_in[m_own*ST +: ST] : '0);
    check_eq("rot_quad", cordic_rot_quad_in, g ? rq_rot_quad_in[m_own*2 +: 2] : '0);
    check_eq("rq_vec_opvld", rq_vec_opvld, (act && m_vc > 0 && cordic_vec_opvld) ? oh : '0);
    check_eq("rq_rot_opvld", rq_rot_opvld, (act && m_rc > 0 && cordic_rot_opvld) ? oh : '0);
    check_eq("err", err, m_err);
    check_eq("nrst", cordic_nrst, rstn && (m_phase != 3));
    check_eq("vec_cnt", dbg_vec_cnt, m_vc);
    check_eq("rot_cnt", dbg_rot_cnt, m_rc);
    if (rq_vec_opvld[0]) pulses0++;
    if (rstn && !cordic_nrst) nrst_low++;
    if (!rstn) begin
      model_reset();
    end else begin
      m_vc = count_after(m_vc, ve, cordic_vec_opvld, m_err);
      m_rc = count_after(m_rc, re, cordic_rot_opvld, m_err);
      case (m_phase)
        0: if (req != '0) begin
          found = 1'b0;
          for (int i = 1; i <= N; i++) begin
            k = (m_last + i) % N;
            if (!found && req[k]) begin
              found = 1'b1; m_own = k; m_last = k;
            end
          end
          m_phase = 1;
        end
        1: if (!req[m_own]) begin
          if (m_vc == 0 && m_rc == 0) quiet_exit(); else m_phase = 2;
        end
        2: if (m_vc == 0 && m_rc == 0) quiet_exit();
        default: begin
          m_fl++;
          if (m_fl == 2) m_phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    vp = {vp[ST-2:0], ve};
    rp = {rp[ST-2:0], re};
    if (!rstn) begin vp = '0; rp = '0; end
    upd_opvld();
  endtask

  // ---------------- drivers ----------------
  task automatic clr_inputs();
    req = '0; rq_vec_en = '0; rq_rot_en = '0;
    spur_vec = 1'b0; spur_rot = 1'b0;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      rq_vec_xin[k*DW +: DW] = $urandom;
      rq_vec_yin[k*DW +: DW] = $urandom;
      rq_rot_xin[k*DW +: DW] = $urandom;
      rq_rot_yin[k*DW +: DW] = $urandom;
      rq_rot_angle_in[k*AW +: AW] = AW'($urandom);
      rq_rot_microRot_ext_in[k*ST +: ST] = ST'($urandom);
      rq_rot_quad_in[k*2 +: 2] = 2'($urandom_range(0, 3));
    end
    rq_vec_angle_calc_en = N'($urandom);
    rq_rot_microRot_ext_vld = N'($urandom);
    rq_rot_angle_microRot_n = N'($urandom);
  endtask

  // Asynchronous reset asserted mid-cycle; effects checked before any edge.
  task automatic do_reset();
    clr_inputs();
    rstn = 1'b0;
    #1;
    check_eq("rst_gnt", gnt, '0);
    check_eq("rst_state", dbg_state, 2'd0);
    check_eq("rst_vec_cnt", dbg_vec_cnt, '0);
    check_eq("rst_rot_cnt", dbg_rot_cnt, '0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_nrst", cordic_nrst, 1'b0);
    model_reset();
    vp = '0; rp = '0; stub_on = 1'b1;
    upd_opvld();
    check_eq("rst_opvld", {rq_vec_opvld, rq_rot_opvld}, '0);
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_phase != 0 && n < 100) begin step(); n++; end
    step();
    check_eq(tag, dbg_state, 2'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    model_reset();
    rand_data();
    do_reset();

    // Single owner, three vectoring ops, three routed result pulses.
    req = 2'b01;
    step();
    check_eq("first_gnt", gnt, 2'b01);
    pulses0 = 0;
    rq_vec_en = 2'b01;
    repeat (3) begin rand_data(); step(); end
    rq_vec_en = '0;
    n = 0;
    while (pulses0 < 3 && n < 40) begin step(); n++; end
    req = '0;
    wait_idle("idle_after_3ops");
    check_eq("vec_pulses", pulses0, 3);

    // Both request; owner 0 releases and must drain before requester 1 wins.
    do_reset();
    req = 2'b11;
    step();
    nrst_low = 0;
    rq_vec_en = 2'b11;
    repeat (2) begin rand_data(); step(); end
    rq_vec_en = 2'b10;
    req = 2'b10;
    n = 0;
    while (gnt != 2'b10 && n < 60) begin step(); n++; end
    check_eq("owner1_gnt", gnt, 2'b10);
    check_eq("drain_long", (n >= ST - 2) ? 1 : 0, 1);
`ifdef CORDIC_ARB_FLUSH_EN
    check_eq("nrst_low_cycles", nrst_low, 2);
`else
    check_eq("nrst_low_cycles", nrst_low, 0);
`endif
    repeat (4) begin rand_data(); step(); end
    clr_inputs();
    wait_idle("idle_after_owner1");

    // Rotation en coinciding with a returning opvld leaves the count at 1.
    do_reset();
    req = 2'b01;
    step();
    rq_rot_en = 2'b01;
    step();
    rq_rot_en = '0;
    n = 0;
    while (!cordic_rot_opvld && n < 40) begin step(); n++; end
    rq_rot_en = 2'b01;
    step();
    rq_rot_en = '0;
    check_eq("rot_cnt_same", dbg_rot_cnt, 1);
    req = '0;
    wait_idle("idle_after_rot");

    // Overflow: MAX_OUT+1 back-to-back ops with no results.
    do_reset();
    stub_on = 1'b0;
    upd_opvld();
    req = 2'b01;
    step();
    rq_vec_en = 2'b01;
    repeat (MO + 1) step();
    rq_vec_en = '0;
    check_eq("ovf_err", err, 1'b1);
    check_eq("ovf_cnt", dbg_vec_cnt, MO);

    // Spurious result with nothing outstanding.
    do_reset();
    spur_vec = 1'b1;
    upd_opvld();
    step();
    spur_vec = 1'b0;
    upd_opvld();
    step();
    check_eq("spur_err", err, 1'b1);

    // Reset in the middle of a drain abandons it; requester 0 wins afterwards.
    do_reset();
    req = 2'b01;
    step();
    rq_vec_en = 2'b01;
    repeat (2) step();
    clr_inputs();
    repeat (3) step();
    check_eq("mid_drain_state", dbg_state, 2'd2);
    do_reset();
    req = 2'b11;
    step();
    check_eq("post_rst_gnt", gnt, 2'b01);
    clr_inputs();
    wait_idle("idle_after_rst_test");

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      for (int k = 0; k < N; k++) begin
        rq_vec_en[k] = ($urandom_range(0, 3) == 0);
        rq_rot_en[k] = ($urandom_range(0, 3) == 0);
      end
      spur_vec = ($urandom_range(0, 199) == 0);
      spur_rot = ($urandom_range(0, 199) == 0);
      upd_opvld();
      rand_data();
      step();
    end
    clr_inputs();
    upd_opvld();
    wait_idle("idle_after_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
